pcm_sample_fifo: RTL and testbench
==================================

Name: pcm_sample_fifo

Overview:
Downstream consumer of the CIC/DC-removal stage. Captures each 16-bit PCM sample on its one-cycle valid strobe and buffers it in a small circular FIFO. The FIFO is drained by the TinyQV peripheral register interface through a pop strobe. Provides fill level, a sticky overflow flag and a level-threshold interrupt, so the CPU can read samples in bursts instead of per-sample.

Parameters:
- ADDR_W, 4, log2 of FIFO depth; DEPTH = 2**ADDR_W = 16 entries.
- DATA_W, 16, sample width; matches the signed PCM output of the decimator.

Ports:
- clk  in  1  system/PDM-domain clock; same clock as the decimator.
- rst  in  1  synchronous, active-high reset.
- pcm_in  in  DATA_W  signed PCM sample from the decimator.
- pcm_valid  in  1  one-cycle strobe; pcm_in is valid this cycle.
- rd_pop  in  1  one-cycle strobe from the register read of the DATA register; pops the head entry.
- flush  in  1  one-cycle strobe; empties the FIFO.
- ovf_clr  in  1  one-cycle strobe; clears the overflow flag.
- irq_en  in  1  interrupt enable.
- irq_thresh  in  ADDR_W+1  level at or above which irq asserts.
- rd_data  out  DATA_W  head entry, first-word-fall-through.
- level  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; a sample was dropped.
- irq  out  1  level-sensitive interrupt.

Behaviour:
- Storage: DEPTH x DATA_W register array.
  - Write and read pointers are ADDR_W+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH; the array index is the low ADDR_W bits.
- Reset (rst high at a clk edge): pointers = 0, overflow = 0.
  - Outputs after reset: level = 0, empty = 1, full = 0, irq = 0, rd_data = 0.
  - Array contents are not reset.
- Write: when pcm_valid and the FIFO is not full, store pcm_in at wr_ptr and increment wr_ptr.
  - level and empty reflect the write on the next cycle.
- Pop: when rd_pop and the FIFO is not empty, increment rd_ptr.
  - rd_data shows the next entry on the following cycle.
  - rd_pop while empty is ignored, with no pointer change and no error flag.
- rd_data is combinational from the array at rd_ptr[ADDR_W-1:0], gated to 0 when empty.
  - Latency from a write into an empty FIFO to rd_data valid is 1 cycle.
- Overflow: pcm_valid while full and no accepted pop that cycle.
  - The new sample is dropped (oldest data is preserved) and overflow is set.
  - overflow stays high until ovf_clr, flush or rst.
- Simultaneous events:
  - pcm_valid and rd_pop while full: pop and write both happen, level stays DEPTH, no overflow.
  - pcm_valid and rd_pop while empty: the write happens, the pop is ignored, level becomes 1.
  - Otherwise, with both strobes: both happen and level is unchanged.
  - ovf_clr in the same cycle as a new overflow event: set wins.
- Flush: wr_ptr and rd_ptr are set to 0, so level = 0 next cycle.
  - overflow is also cleared.
  - flush has priority over a same-cycle write or pop; that sample is discarded.
- level is registered or derived as wr_ptr - rd_ptr, (ADDR_W+1)-bit modular subtraction; full and empty are derived from level.
- irq = irq_en && (level >= irq_thresh) && (irq_thresh != 0).
  - irq_thresh greater than DEPTH never fires.
  - irq is combinational from registered state, so it carries no glitch from the input strobes.

Optional Feature:
Macro PCM_FIFO_PEAK_EN.
- Defined: adds input peak_clr (1 bit) and output peak_abs (DATA_W-1 bits).
  - On every pcm_valid, including dropped samples, peak_abs <= max(peak_abs, |pcm_in|).
  - |−32768| saturates to 32767.
  - peak_clr zeroes peak_abs; a same-cycle sample then loads |pcm_in|.
  - rst zeroes peak_abs.
- Undefined: neither port exists and no peak logic is synthesized.

Decomposition:
- Shared package pdm_mic_pkg:
  - PCM_W = 16.
  - FIFO_ADDR_W default.
  - pcm_sample_t typedef, signed [15:0].
  - Register offsets for DATA, STATUS (level/empty/full/overflow) and CTRL (irq_en/thresh/flush/ovf_clr).
- One natural sub-module: pcm_peak_tracker, the abs/saturate/max register. It is instantiated only under PCM_FIFO_PEAK_EN.
- The FIFO core stays in pcm_sample_fifo.

Test Plan:
- Reset, then no stimulus -> level = 0, empty = 1, full = 0, rd_data = 0, irq = 0, overflow = 0.
- Write 3 samples (0x1234, 0x8000, 0x7FFF), then 3 pops -> rd_data sequence 0x1234, 0x8000, 0x7FFF; level 3→2→1→0; the 4th pop is ignored and level stays 0.
- Write 17 samples 1..17 with no pops -> full = 1, overflow = 1, level = 16; draining yields 1..16 (17 dropped); ovf_clr → overflow = 0.
- While full, pcm_valid = 0x00AA together with rd_pop -> level stays 16, overflow stays 0, and 0x00AA is the last entry read out.
- irq_en = 1, irq_thresh = 4: after 3 writes irq = 0, after the 4th irq = 1; one pop → irq = 0; flush → level = 0, irq = 0.
- With PCM_FIFO_PEAK_EN: samples -5, 300, -32768, 10 -> peak_abs = 5, 300, 32767, 32767; peak_clr → 0; rst mid-sequence → 0.

Source files
------------

// File: rtl/pdm_mic_pkg.sv
// pdm_mic_pkg: shared widths, sample type and register offsets for the PDM microphone peripheral
package pdm_mic_pkg;
  localparam int PCM_W = 16;
  localparam int FIFO_ADDR_W = 4;
  typedef logic signed [PCM_W-1:0] pcm_sample_t;
  localparam logic [3:0] REG_DATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL = 4'h8;
endpackage

// File: rtl/pcm_peak_tracker.sv
// pcm_peak_tracker: running maximum of saturated |sample| over every valid strobe
module pcm_peak_tracker
  import pdm_mic_pkg::*;
#(
  parameter int DATA_W = PCM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-2:0] peak_abs
);
  logic [DATA_W-2:0] peak_q, peak_d, mag, base;
  logic [DATA_W-1:0] neg;
  // magnitude with the most negative code saturated; clear applies before a same-cycle sample
  always_comb begin
    neg = -sample;
    mag = sample == {1'b1, {(DATA_W-1){1'b0}}} ? {(DATA_W-1){1'b1}}
        : sample[DATA_W-1] ? neg[DATA_W-2:0] : sample[DATA_W-2:0];
    base = clr ? '0 : peak_q;
    peak_d = valid && mag > base ? mag : base;
  end
  // peak register
  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else peak_q <= peak_d;
  end
  assign peak_abs = peak_q;
endmodule

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo: 16-deep FWFT PCM sample buffer with level, sticky overflow and threshold irq (optional peak meter: PCM_FIFO_PEAK_EN)
module pcm_sample_fifo
  import pdm_mic_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = PCM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pcm_in,
  input  logic              pcm_valid,
  input  logic              rd_pop,
  input  logic              flush,
  input  logic              ovf_clr,
  input  logic              irq_en,
  input  logic [ADDR_W:0]   irq_thresh,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              irq
`ifdef PCM_FIFO_PEAK_EN
  ,
  input  logic              peak_clr,
  output logic [DATA_W-2:0] peak_abs
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0] wr_q, wr_d, rd_q, rd_d;
  logic ovf_q, ovf_d, pop_ok, push, ovf_evt;
  assign level = wr_q - rd_q;
  assign empty = level == '0;
  assign full = level == (ADDR_W+1)'(DEPTH);
  assign overflow = ovf_q;
  assign rd_data = empty ? '0 : mem_q[rd_q[ADDR_W-1:0]];
  assign irq = irq_en && level >= irq_thresh && irq_thresh != '0;
  // a pop frees the slot for a same-cycle write when full; flush overrides everything
  always_comb begin
    pop_ok = rd_pop && !empty;
    push = pcm_valid && (!full || pop_ok);
    ovf_evt = pcm_valid && full && !pop_ok;
    wr_d = flush ? '0 : wr_q + (ADDR_W+1)'(push);
    rd_d = flush ? '0 : rd_q + (ADDR_W+1)'(pop_ok);
    ovf_d = flush ? 1'b0 : ovf_evt ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
  end
  // pointer and overflow state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
    end
  end
  // sample storage, not reset
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q[ADDR_W-1:0]] <= pcm_in;
  end
`ifdef PCM_FIFO_PEAK_EN
  pcm_peak_tracker #(.DATA_W(DATA_W)) u_peak (
    .clk(clk),
    .rst(rst),
    .clr(peak_clr),
    .valid(pcm_valid),
    .sample(pcm_in),
    .peak_abs(peak_abs)
  );
`endif
endmodule

// File: tb/tb_pcm_sample_fifo.sv
// tb_pcm_sample_fifo: directed plus randomized checks against a queue-based model
module tb_pcm_sample_fifo;
  logic clk = 1'b0;
  logic rst, pcm_valid, rd_pop, flush, ovf_clr, irq_en;
  logic [15:0] pcm_in, rd_data;
  logic [4:0] irq_thresh, level;
  logic empty, full, overflow, irq;
  logic peak_clr;
`ifdef PCM_FIFO_PEAK_EN
  logic [14:0] peak_abs;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] q[$];
  bit m_ovf;
  int m_peak;
  always #5 clk = ~clk;
  pcm_sample_fifo dut (
    .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_valid(pcm_valid), .rd_pop(rd_pop),
    .flush(flush), .ovf_clr(ovf_clr), .irq_en(irq_en), .irq_thresh(irq_thresh),
    .rd_data(rd_data), .level(level), .empty(empty), .full(full),
    .overflow(overflow), .irq(irq)
`ifdef PCM_FIFO_PEAK_EN
    , .peak_clr(peak_clr), .peak_abs(peak_abs)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("level", 32'(level), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_data", 32'(rd_data), q.size() ? 32'(q[0]) : 0);
    chk("irq", 32'(irq), 32'(irq_en && irq_thresh != 0 && q.size() >= int'(irq_thresh)));
`ifdef PCM_FIFO_PEAK_EN
    chk("peak_abs", 32'(peak_abs), m_peak);
`endif
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic p, input logic f,
                      input logic oc, input logic pc, input logic r);
    bit popped, ovf_new;
    int s, mag;
    pcm_valid = v; pcm_in = d; rd_pop = p; flush = f; ovf_clr = oc; peak_clr = pc; rst = r;
    @(posedge clk);
    s = int'($signed(d));
    mag = s < 0 ? -s : s;
    if (mag > 32767) mag = 32767;
    if (r) begin
      q.delete(); m_ovf = 0; m_peak = 0;
    end else begin
      if (pc) m_peak = 0;
      if (v && mag > m_peak) m_peak = mag;
      if (f) begin
        q.delete(); m_ovf = 0;
      end else begin
        popped = p && q.size() > 0;
        ovf_new = v && q.size() == 16 && !popped;
        if (popped) void'(q.pop_front());
        if (v && !ovf_new) q.push_back(d);
        m_ovf = ovf_new ? 1'b1 : oc ? 1'b0 : m_ovf;
      end
    end
    @(negedge clk);
    pcm_valid = 0; rd_pop = 0; flush = 0; ovf_clr = 0; peak_clr = 0; rst = 0;
    check_all();
  endtask
  task automatic wr(input logic [15:0] d); step(1, d, 0, 0, 0, 0, 0); endtask
  task automatic pop(); step(0, 0, 1, 0, 0, 0, 0); endtask
  initial begin
    logic [15:0] seq [3];
    int pv;
    seq[0] = 16'h1234; seq[1] = 16'h8000; seq[2] = 16'h7FFF;
    irq_en = 0; irq_thresh = 0;
    pcm_valid = 0; pcm_in = 0; rd_pop = 0; flush = 0; ovf_clr = 0; peak_clr = 0; rst = 1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_rd_data", 32'(rd_data), 0);
    for (int i = 0; i < 3; i++) wr(seq[i]);
    for (int i = 0; i < 3; i++) begin
      chk("seq_data", 32'(rd_data), 32'(seq[i]));
      pop();
      chk("seq_level", 32'(level), 32'(2 - i));
    end
    pop();
    chk("pop_empty_level", 32'(level), 0);
    for (int i = 1; i <= 17; i++) wr(16'(i));
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(rd_data), i);
      pop();
    end
    step(0, 0, 0, 0, 1, 0, 0);
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) wr(16'(i + 100));
    step(1, 16'h00AA, 1, 0, 0, 0, 0);
    chk("fullpop_level", 32'(level), 16);
    chk("fullpop_ovf", 32'(overflow), 0);
    for (int i = 0; i < 15; i++) pop();
    chk("fullpop_last", 32'(rd_data), 32'h00AA);
    pop();
    irq_en = 1; irq_thresh = 4;
    for (int i = 0; i < 3; i++) wr(16'(i));
    chk("irq_3", 32'(irq), 0);
    wr(16'h55);
    chk("irq_4", 32'(irq), 1);
    pop();
    chk("irq_pop", 32'(irq), 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("flush_level", 32'(level), 0);
    irq_thresh = 17;
    for (int i = 0; i < 16; i++) wr(16'(i));
    chk("irq_thresh17", 32'(irq), 0);
    step(1, 16'h77, 1, 1, 0, 0, 0);
    chk("flush_prio", 32'(level), 0);
`ifdef PCM_FIFO_PEAK_EN
    step(0, 0, 0, 0, 0, 1, 0);
    wr(16'hFFFB); chk("peak_m5", 32'(peak_abs), 5);
    wr(16'd300); chk("peak_300", 32'(peak_abs), 300);
    wr(16'h8000); chk("peak_sat", 32'(peak_abs), 32767);
    wr(16'd10); chk("peak_hold", 32'(peak_abs), 32767);
    step(0, 0, 0, 0, 0, 1, 0); chk("peak_clr", 32'(peak_abs), 0);
    wr(16'd42);
    step(0, 0, 0, 0, 0, 0, 1); chk("peak_rst", 32'(peak_abs), 0);
`endif
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      pv = ((i / 200) % 2) ? 30 : 80;
      if (i % 97 == 0) begin
        irq_en = 1'($urandom); irq_thresh = 5'($urandom_range(0, 20));
      end
      step($urandom_range(0, 99) < pv,
           ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom),
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 499) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
